// File: rtl/alu_multicycle_if.sv
// Request/response bundle for the multi-cycle ALU: operand handshake in,
// result handshake out.
interface alu_multicycle_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;
  logic                  illegal;

  // Producer of requests / consumer of results.
  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, illegal
  );

  // The ALU itself.
  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, illegal
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle integer ALU for the execute stage. Logic, arithmetic, compare
// and branch ops finish in one cycle; shifts walk a serial shifter one bit
// position per cycle. Results are registered and held until consumed.
module alu_multicycle #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  alu_multicycle_if.slave bus
);
  localparam int unsigned SW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_XOR = 4'b0101,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLL = 4'b0111,
    OP_SRL = 4'b1111,
    OP_SRA = 4'b1110,
    OP_SLT = 4'b1100,
    OP_EQ  = 4'b1000,
    OP_NE  = 4'b1001
  } op_e;

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  illegal_q, illegal_d;
  logic                  out_valid_q, out_valid_d;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_ill;
  logic                  in_is_shift;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] shift_next;

  assign shamt       = bus.SrcB[SW-1:0];
  assign in_is_shift = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                       (bus.Operation == OP_SRA);

  // Single-cycle datapath for every non-shift op code.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.Operation)
      OP_AND:  alu_res = bus.SrcA & bus.SrcB;
      OP_OR:   alu_res = bus.SrcA | bus.SrcB;
      OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
      OP_ADD:  alu_res = bus.SrcA + bus.SrcB;
      OP_SUB:  alu_res = bus.SrcA - bus.SrcB;
      OP_SLT:  alu_res = DATA_WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
      OP_EQ:   alu_res = DATA_WIDTH'(bus.SrcA == bus.SrcB);
      OP_NE:   alu_res = DATA_WIDTH'(bus.SrcA != bus.SrcB);
      OP_SLL, OP_SRL, OP_SRA: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // One bit position of the serial shifter, direction/fill by latched op.
  always_comb begin
    shift_next = '0;
    case (op_q)
      OP_SLL:  shift_next = {shreg_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, shreg_q[DATA_WIDTH-1:1]};
      default: shift_next = {shreg_q[DATA_WIDTH-1], shreg_q[DATA_WIDTH-1:1]};
    endcase
  end

  // Next-state and register updates for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.Operation;
          if (in_is_shift && (shamt != '0)) begin
            shreg_d = bus.SrcA;
            cnt_d   = shamt;
            state_d = S_SHIFT;
          end else begin
            result_d    = in_is_shift ? bus.SrcA : alu_res;
            zero_d      = in_is_shift ? (bus.SrcA == '0) : (alu_res == '0);
            illegal_d   = in_is_shift ? 1'b0 : alu_ill;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        shreg_d = shift_next;
        cnt_d   = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          result_d    = shift_next;
          zero_d      = (shift_next == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vector table, hand-written
// backpressure and reset-mid-shift sequences, then randomized ops against a
// plain-arithmetic reference model.
module tb_alu_multicycle;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  alu_multicycle_if #(.DATA_WIDTH(DW)) bus ();
  alu_multicycle #(.DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [DW-1:0] res;
    logic          ill;
    int unsigned   lat;
  } exp_t;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int unsigned   hold;
    logic [DW-1:0] exp_res;
    logic          exp_ill;
    int unsigned   exp_lat;
  } vec_t;

  // Reference model: result, illegal flag and accept-to-valid latency.
  function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b);
    exp_t e;
    int unsigned sh;
    sh = b % DW;
    e.res = '0;
    e.ill = 1'b0;
    e.lat = 1;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0101: e.res = a ^ b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0111: begin e.res = a << sh; e.lat = 1 + sh; end
      4'b1111: begin e.res = a >> sh; e.lat = 1 + sh; end
      4'b1110: begin e.res = $unsigned($signed(a) >>> sh); e.lat = 1 + sh; end
      4'b1100: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: e.res = (a == b) ? 1 : 0;
      4'b1001: e.res = (a != b) ? 1 : 0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency, hold the result for `hold` cycles.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input int unsigned hold, input exp_t e);
    int unsigned waits = 0;
    int unsigned lat = 0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.Operation = 4'($urandom);
    bus.SrcA      = $urandom;
    bus.SrcB      = $urandom;
    do begin
      @(negedge clk);
      lat++;
      if (bus.in_ready) busy_ok = 1'b0;
    end while (!bus.out_valid && lat < DW + 5);
    chk({tag, " latency"}, 64'(lat), 64'(e.lat));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    chk({tag, " result"}, 64'(bus.ALUResult), 64'(e.res));
    chk({tag, " zero"}, 64'(bus.Zero), 64'(e.res == '0));
    chk({tag, " illegal"}, 64'(bus.illegal), 64'(e.ill));
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      chk({tag, " hold"}, {bus.out_valid, bus.in_ready, bus.Zero, bus.illegal, bus.ALUResult},
          {1'b1, 1'b0, (e.res == '0), e.ill, e.res});
    end
    bus.out_ready = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [3:0] op;
    logic [DW-1:0] a, b;
    bit saw;

    vecs.push_back('{4'b0010, 32'hFFFF_FFFF, 32'h1,        0, 32'h0,         1'b0, 1});
    vecs.push_back('{4'b1110, 32'h8000_0000, 32'h24,       0, 32'hF800_0000, 1'b0, 5});
    vecs.push_back('{4'b1111, 32'h8000_0000, 32'h24,       0, 32'h0800_0000, 1'b0, 5});
    vecs.push_back('{4'b0111, 32'h1234,      32'h20,       0, 32'h1234,      1'b0, 1});
    vecs.push_back('{4'b1100, 32'hFFFF_FFFF, 32'h1,        0, 32'h1,         1'b0, 1});
    vecs.push_back('{4'b1100, 32'h1,         32'hFFFF_FFFF, 0, 32'h0,        1'b0, 1});
    vecs.push_back('{4'b0011, 32'h7,         32'h9,        0, 32'h0,         1'b1, 1});
    vecs.push_back('{4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 32'h00F0_1200, 1'b0, 1});
    vecs.push_back('{4'b0110, 32'h5,         32'h7,        1, 32'hFFFF_FFFE, 1'b0, 1});
    vecs.push_back('{4'b0111, 32'h1,         32'h1F,       0, 32'h8000_0000, 1'b0, 32});
    vecs.push_back('{4'b1001, 32'h3,         32'h3,        0, 32'h0,         1'b0, 1});
    vecs.push_back('{4'b0101, 32'hAAAA_5555, 32'hFFFF_0000, 0, 32'h5555_5555, 1'b0, 1});
    vecs.push_back('{4'b1110, 32'h7FFF_FFF0, 32'h104,      2, 32'h07FF_FFFF, 1'b0, 5});
    vecs.push_back('{4'b1010, 32'h1,         32'h1,        0, 32'h0,         1'b1, 1});
    vecs.push_back('{4'b0001, 32'h0,         32'h0,        0, 32'h0,         1'b0, 1});

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.Operation = '0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset state", {bus.in_ready, bus.out_valid, bus.Zero, bus.illegal, bus.ALUResult},
        {1'b1, 1'b0, 1'b1, 1'b0, 32'h0});

    foreach (vecs[i]) begin
      e.res = vecs[i].exp_res;
      e.ill = vecs[i].exp_ill;
      e.lat = vecs[i].exp_lat;
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, e);
    end

    // Backpressure on BEQ, then in_ready returns only after the handshake.
    e.res = 32'h1; e.ill = 1'b0; e.lat = 1;
    run_op("beq_bp", 4'b1000, 32'h5, 32'h5, 3, e);
    @(negedge clk);
    chk("beq_bp release", {bus.in_ready, bus.out_valid}, 2'b10);

    // Reset in the middle of a 31-position shift discards it silently.
    @(negedge clk);
    bus.Operation = 4'b0111; bus.SrcA = 32'h1; bus.SrcB = 32'h1F; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    saw = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid-shift reset state", {bus.in_ready, bus.out_valid, bus.Zero, bus.illegal, bus.ALUResult},
        {1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw = 1'b1;
    end
    chk("mid-shift no out_valid", 64'(saw), 64'd0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (n % 5 == 0) a = 32'h8000_0000 | a;
      if (n % 7 == 0) b = a;
      run_op($sformatf("rand%0d op%0h", n, op), op, a, b, $urandom_range(0, 2), model(op, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
